c7bcsr_intc: RTL
================

# c7bcsr_intc

Interrupt pending/request controller for the c7b CSR unit. Captures the one-cycle `intr` pulse from the CSR timer into the TI pending bit, synchronizes external hardware interrupt lines, holds software interrupt bits, and presents the ESTAT.IS pending vector. It masks pending interrupts with ECFG.LIE and CRMD.IE and drives a registered request/acknowledge handshake toward the pipeline's exception logic. TICLR writes clear TI.

## Interface
Parameters:
- `HWI_N`, 8: number of hardware interrupt lines. Fixed at 8 for the ESTAT layout below.
- `SYNC_STAGES`, 2: flop stages on each `hwi` line. Minimum 2.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `timer_intr`  in  1  timer expiry pulse.
- `hwi`  in  HWI_N  asynchronous external interrupt levels.
- `swi_wr`  in  1  CSR write strobe for ESTAT.IS[1:0].
- `swi_wdata`  in  2  SWI write data.
- `ticlr_wr`  in  1  CSR write strobe for TICLR.
- `ticlr_wdata`  in  1  TICLR.CLR bit.
- `lie`  in  12  ECFG.LIE mask, same bit layout as `estat_is`.
- `gie`  in  1  CRMD.IE global enable.
- `estat_is`  out  12  pending vector: [1:0] SWI, [9:2] HWI, [10] reads 0, [11] TI.
- `int_req`  out  1  interrupt request to the pipeline, registered.
- `int_vec`  out  4  index of the requested interrupt, 0..11; valid while `int_req` is high.
- `int_ack`  in  1  pipeline has taken the interrupt, single-cycle.

## Operation
- **Reset.** All flops go to 0. `estat_is`=0, `int_req`=0, `int_vec`=0, FSM=IDLE.
- **TI.**
  - `timer_intr` is registered to `ti_q`. Rising edge is `timer_intr & ~ti_q`.
  - On a rising edge, TI is set to 1.
  - On `ticlr_wr & ticlr_wdata`, TI is cleared to 0.
  - If set and clear occur in the same cycle, set wins.
  - A level that stays high sets TI once only.
- **HWI.** Each line passes through `SYNC_STAGES` flops. `estat_is[9:2]` is the synchronized level and is not latched.
- **SWI.** On `swi_wr`, `estat_is[1:0]` <= `swi_wdata`. Otherwise the bits hold.
- **Bit 10.** Constant 0.
- **Masking.** `pend = estat_is & lie`. `fire = gie & |pend`.
- **Priority.** Highest set index in `pend` wins (TI=11 is highest, SWI0=0 is lowest).
- **FSM, 3 states.**
  - IDLE: if `fire`, go to REQ. `int_req`<=1 and `int_vec`<=priority index of `pend`, both set on that edge.
  - REQ: `int_req` and `int_vec` are held frozen.
    - If `int_ack`, go to BLOCK with `int_req`<=0.
    - Else if `!fire`, the request is withdrawn: go to IDLE with `int_req`<=0.
    - `int_ack` takes precedence over withdrawal in the same cycle.
  - BLOCK: `int_req`=0. Stay until `gie`==0 is sampled, then go to IDLE. This prevents a re-request before CRMD.IE clears. If `gie` never drops, the FSM stays in BLOCK.
- `int_ack` sampled outside REQ is ignored.
- `int_vec` does not change while in REQ, even if a higher-priority interrupt becomes pending.

## Timing
- **Timer path.** Rising edge of `timer_intr` sampled at edge N. `estat_is[11]`=1 after edge N. `int_req`=1 after edge N+1, if enabled and FSM is IDLE.
- **HWI path.** `hwi` change to `estat_is`: `SYNC_STAGES` cycles. To `int_req`: `SYNC_STAGES`+1 cycles.
- **SWI / TICLR writes.** Visible in `estat_is` the cycle after the strobe.
- **Ack.** `int_ack` sampled at edge M: `int_req`=0 after M.
- **Withdrawal.** `int_req` falls the cycle after `fire` is sampled low.
- **Mask/enable changes.** Changes to `lie`/`gie` affect the next edge. There is no combinational path from any input to `int_req`, `int_vec` or `estat_is`.
- **Reset.** Asserting `resetn` mid-request drops `int_req` immediately (async). The FSM restarts in IDLE.

## Test plan
- **Timer pulse, TI enabled.** Reset. `lie`=0x800, `gie`=1. One-cycle `timer_intr` at edge 5 -> `estat_is`=0x800 after edge 5; `int_req`=1, `int_vec`=11 after edge 6. `int_ack` at edge 9 -> `int_req`=0 after edge 9. Drop `gie` at edge 11 -> FSM returns to IDLE; TI still pending. Raise `gie` -> new request with `int_vec`=11.
- **TICLR.** TI pending. `ticlr_wr`=1, `ticlr_wdata`=1 -> `estat_is[11]`=0 next cycle. Same write coinciding with a new `timer_intr` rising edge -> TI stays 1.
- **Held timer level.** `timer_intr` high for 10 cycles, then TICLR -> TI=0 and stays 0 while `timer_intr` remains high.
- **HWI sync and priority.** `hwi[3]` asserted (IS bit 5), `lie`=0xFFF, `gie`=1 -> `estat_is[5]`=1 after 2 cycles, `int_req` with `int_vec`=5 after 3 cycles. Pulse TI while in REQ -> `int_vec` stays 5. After ack/BLOCK/IDLE -> next request carries `int_vec`=11.
- **Withdrawal.** SWI write 0x1, `lie`=0x1, `gie`=1 -> `int_req`=1 with `int_vec`=0. Write `lie`=0 before any ack -> `int_req`=0 one cycle later, FSM=IDLE. An `int_ack` arriving afterwards is ignored.
- **Async reset.** Assert `resetn`=0 while `int_req`=1 -> all outputs 0 without a clock edge. Release -> no request until a new event occurs.

Source files
------------

// File: rtl/c7bcsr_intc.sv
// rtl/c7bcsr_intc.sv - interrupt pending/request controller for the c7b CSR unit
//
// Purpose:
//   Collects interrupt sources into the ESTAT.IS pending vector and raises a
//   registered request toward the pipeline's exception logic.
//   - TI: set on a rising edge of the timer pulse, cleared by TICLR.CLR.
//   - HWI: external levels after a SYNC_STAGES-deep synchronizer.
//   - SWI: two software bits written through ESTAT.IS[1:0].
//   Pending bits are masked by ECFG.LIE and CRMD.IE. The highest pending
//   index is requested through an IDLE/REQ/BLOCK handshake.
//
// Ports:
//   clk          in   sole clock
//   resetn       in   asynchronous active-low reset
//   timer_intr   in   timer expiry pulse
//   hwi          in   [HWI_N-1:0] asynchronous external interrupt levels
//   swi_wr       in   write strobe for ESTAT.IS[1:0]
//   swi_wdata    in   [1:0] SWI write data
//   ticlr_wr     in   write strobe for TICLR
//   ticlr_wdata  in   TICLR.CLR bit
//   lie          in   [11:0] ECFG.LIE mask, same layout as estat_is
//   gie          in   CRMD.IE global enable
//   estat_is     out  [11:0] {TI, 0, HWI[7:0], SWI[1:0]}
//   int_req      out  registered interrupt request
//   int_vec      out  [3:0] index of the requested interrupt
//   int_ack      in   single-cycle acknowledge from the pipeline

module c7bcsr_intc #(
  parameter int HWI_N       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             timer_intr,
  input  logic [HWI_N-1:0] hwi,
  input  logic             swi_wr,
  input  logic [1:0]       swi_wdata,
  input  logic             ticlr_wr,
  input  logic             ticlr_wdata,
  input  logic [11:0]      lie,
  input  logic             gie,
  output logic [11:0]      estat_is,
  output logic             int_req,
  output logic [3:0]       int_vec,
  input  logic             int_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BLOCK = 2'd2;

  // Timer edge detect and TI pending bit
  logic ti_q, ti_d;
  logic ti_pend_q, ti_pend_d;
  logic ti_rise;

  // HWI synchronizer chain; the last stage is what software sees
  logic [HWI_N-1:0] hwi_sync_q [SYNC_STAGES];
  logic [HWI_N-1:0] hwi_sync_d [SYNC_STAGES];

  // Software interrupt bits
  logic [1:0] swi_q, swi_d;

  // Request FSM
  logic [1:0] state_q, state_d;
  logic       int_req_q, int_req_d;
  logic [3:0] int_vec_q, int_vec_d;

  logic [11:0] pend;
  logic        fire;
  logic [3:0]  prio_idx;

  assign ti_rise = timer_intr & ~ti_q;

  always_comb begin
    ti_d      = timer_intr;
    ti_pend_d = ti_pend_q;
    // Clear first so that a coincident rising edge wins.
    if (ticlr_wr && ticlr_wdata) begin
      ti_pend_d = 1'b0;
    end
    if (ti_rise) begin
      ti_pend_d = 1'b1;
    end
  end

  always_comb begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      hwi_sync_d[s] = hwi_sync_q[s];
    end
    hwi_sync_d[0] = hwi;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      hwi_sync_d[s] = hwi_sync_q[s-1];
    end
  end

  always_comb begin
    swi_d = swi_q;
    if (swi_wr) begin
      swi_d = swi_wdata;
    end
  end

  // Everything in the pending vector comes straight from flops, so there is
  // no combinational path from any input to estat_is.
  assign estat_is = {ti_pend_q, 1'b0, hwi_sync_q[SYNC_STAGES-1], swi_q};

  assign pend = estat_is & lie;
  assign fire = gie & (|pend);

  // Highest set index wins: later iterations overwrite earlier ones.
  always_comb begin
    prio_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (pend[i]) begin
        prio_idx = i[3:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_vec_d = prio_idx;
        end
      end
      ST_REQ: begin
        // int_vec stays frozen for the whole request, even if a
        // higher-priority source shows up meanwhile.
        if (int_ack) begin
          state_d   = ST_BLOCK;
          int_req_d = 1'b0;
        end else if (!fire) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_BLOCK: begin
        // Wait for the handler to clear CRMD.IE before re-arming, otherwise
        // the still-pending source would immediately re-request.
        int_req_d = 1'b0;
        if (!gie) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        int_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ti_q      <= 1'b0;
      ti_pend_q <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        hwi_sync_q[s] <= '0;
      end
      swi_q     <= 2'b00;
      state_q   <= ST_IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= 4'd0;
    end else begin
      ti_q      <= ti_d;
      ti_pend_q <= ti_pend_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        hwi_sync_q[s] <= hwi_sync_d[s];
      end
      swi_q     <= swi_d;
      state_q   <= state_d;
      int_req_q <= int_req_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;

endmodule
